// File: rtl/priority_decoder_seq.sv
// Buffered binary-to-one-hot decoder: codes arrive over valid/ready into a small FIFO
// and each one is replayed as a registered one-hot pattern held for HOLD cycles.
module priority_decoder_seq #(
  parameter int N_OUT  = 8,
  parameter int W_CODE = $clog2(N_OUT),
  parameter int DEPTH  = 4,
  parameter int HOLD   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [W_CODE-1:0]        code_in,
  input  logic                     code_valid,
  output logic                     code_ready,
  output logic [N_OUT-1:0]         y,
  output logic                     y_valid,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [W_CODE:0] N_LIM = (W_CODE+1)'(N_OUT);

  typedef enum logic {IDLE, DRIVE} state_t;

  logic [W_CODE-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  state_t            r_state;
  logic [HW-1:0]     r_hold;
  logic [N_OUT-1:0]  r_y;
  logic              r_y_valid;
  logic              r_err;

  state_t            w_next_state;
  logic              w_push;
  logic              w_pop;
  logic              w_nonempty;
  logic [W_CODE-1:0] w_head;
  logic              w_head_ok;
  logic [N_OUT-1:0]  w_dec;
  logic [N_OUT-1:0]  w_y_nxt;
  logic [HW-1:0]     w_hold_nxt;
  logic              w_err_nxt;

  assign code_ready = (r_count != CW'(DEPTH));
  assign w_push     = code_valid && code_ready;
  assign w_nonempty = (r_count != '0);
  assign w_head     = r_mem[r_rptr];
  assign w_head_ok  = ({1'b0, w_head} < N_LIM);
  assign w_dec      = {{(N_OUT-1){1'b0}}, 1'b1} << w_head;

  // FIFO storage; pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= code_in;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_hold    <= '0;
      r_y       <= '0;
      r_y_valid <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_hold    <= w_hold_nxt;
      r_y       <= w_y_nxt;
      r_y_valid <= |w_y_nxt;
      r_err     <= w_err_nxt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_nonempty && w_head_ok) begin
          w_next_state = DRIVE;
        end
      end
      DRIVE: begin
        if (r_hold == '0) begin
          w_next_state = (w_nonempty && w_head_ok) ? DRIVE : IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Pop decision lives here so a pattern ending with data queued reloads on the same edge
  always_comb begin
    w_pop      = 1'b0;
    w_y_nxt    = r_y;
    w_hold_nxt = r_hold;
    w_err_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        w_y_nxt = '0;
        if (w_nonempty) begin
          w_pop = 1'b1;
          if (w_head_ok) begin
            w_y_nxt    = w_dec;
            w_hold_nxt = HW'(HOLD - 1);
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      DRIVE: begin
        if (r_hold != '0) begin
          w_hold_nxt = r_hold - 1'b1;
        end else if (w_nonempty) begin
          w_pop = 1'b1;
          if (w_head_ok) begin
            w_y_nxt    = w_dec;
            w_hold_nxt = HW'(HOLD - 1);
          end else begin
            w_y_nxt   = '0;
            w_err_nxt = 1'b1;
          end
        end else begin
          w_y_nxt = '0;
        end
      end
      default: begin
        w_y_nxt = '0;
      end
    endcase
  end

  assign y          = r_y;
  assign y_valid    = r_y_valid;
  assign err        = r_err;
  assign fifo_count = r_count;

endmodule
